// File: rtl/csa_out_axis_packer.sv
// csa_out_axis_packer
// Takes 48-bit CSA results from the calc/RAM output stage, buffers them in a
// small FIFO and packs each pair of results into three 32-bit AXI-Stream
// beats. Every FRAME_RESULTS results the last beat carries tlast.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   in_wen, in_wdata  result write strobe and {out2, out1, out0} payload
//   in_error_full     backpressure to the writer (one slot of headroom)
//   m_axis_*          AXI-Stream master (tvalid/tready/tdata/tlast)
//   axis_m_r_ready    registered "data pending" status bit
//   frame_count       completed frames (tlast handshakes), wraps
//   overflow_count    writes dropped on a full FIFO, saturates
module csa_out_axis_packer #(
  parameter int IN_WIDTH        = 48,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 16,
  parameter int FRAME_RESULTS   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_wen,
  input  logic [IN_WIDTH-1:0]        in_wdata,
  output logic                       in_error_full,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic                       axis_m_r_ready,
  output logic [31:0]                frame_count,
  output logic [15:0]                overflow_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = (FRAME_RESULTS > 2) ? $clog2(FRAME_RESULTS) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_C   = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] TWO_C    = CW'(2);
  localparam logic [RW-1:0] LAST_IDX = RW'(FRAME_RESULTS - 2);
  localparam logic [RW-1:0] IDX_STEP = RW'(2);

  typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       rd_ptr_nxt;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_next;
  logic [RW-1:0]       res_idx;
  logic [15:0]         a_hi;
  logic [IN_WIDTH-1:0] b_reg;
  logic                hs;
  logic                wr_acc;
  logic                pop;
  logic                tvalid_next;

  // The full flag leaves one free slot because the writer samples it
  // at least a cycle before it actually writes.
  assign in_error_full = (count >= FULL_C);

  // Write acceptance looks at the pre-pop count, so a write and a pair pop
  // on the same edge never loses the write.
  assign hs          = m_axis_tvalid & m_axis_tready;
  assign wr_acc      = in_wen & (count != DEPTH_C);
  assign pop         = (count >= TWO_C) & ((state == IDLE) | ((state == B2) & hs));
  assign count_next  = count + {{(CW-1){1'b0}}, wr_acc} - (pop ? TWO_C : '0);
  assign rd_ptr_nxt  = rd_ptr + PW'(1);
  assign tvalid_next = pop | (m_axis_tvalid & ~((state == B2) & hs));

  // Result storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= in_wdata;
    end
  end

  // FIFO bookkeeping, packer FSM, framing and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      res_idx        <= '0;
      a_hi           <= '0;
      b_reg          <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tlast   <= 1'b0;
      axis_m_r_ready <= 1'b0;
      frame_count    <= '0;
      overflow_count <= '0;
    end else begin
      count          <= count_next;
      axis_m_r_ready <= tvalid_next | (count_next >= TWO_C);

      if (wr_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(2);
      end
      if (in_wen && (count == DEPTH_C) && (overflow_count != 16'hFFFF)) begin
        overflow_count <= overflow_count + 16'd1;
      end
      if (hs && m_axis_tlast) begin
        frame_count <= frame_count + 32'd1;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            a_hi          <= mem[rd_ptr][47:32];
            b_reg         <= mem[rd_ptr_nxt];
            m_axis_tdata  <= mem[rd_ptr][31:0];
            m_axis_tvalid <= 1'b1;
            state         <= B0;
          end
        end
        B0: begin
          if (hs) begin
            m_axis_tdata <= {b_reg[15:0], a_hi};
            state        <= B1;
          end
        end
        B1: begin
          if (hs) begin
            m_axis_tdata <= b_reg[47:16];
            m_axis_tlast <= (res_idx == LAST_IDX);
            state        <= B2;
          end
        end
        B2: begin
          if (hs) begin
            m_axis_tlast <= 1'b0;
            res_idx      <= (res_idx == LAST_IDX) ? '0 : res_idx + IDX_STEP;
            // Chain straight into the next pair when one is ready so the
            // stream has no bubble between pairs.
            if (pop) begin
              a_hi         <= mem[rd_ptr][47:32];
              b_reg        <= mem[rd_ptr_nxt];
              m_axis_tdata <= mem[rd_ptr][31:0];
              state        <= B0;
            end else begin
              m_axis_tvalid <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_out_axis_packer.sv
// Directed testbench for csa_out_axis_packer. Inputs change 1 ns after the
// rising edge; a monitor records handshaked beats on the falling edge.
module tb_csa_out_axis_packer;

  logic        clk;
  logic        rst;
  logic        in_wen;
  logic [47:0] in_wdata;
  logic        in_error_full;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        axis_m_r_ready;
  logic [31:0] frame_count;
  logic [15:0] overflow_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] beat_data [$];
  logic        beat_last [$];
  int          beat_cyc  [$];
  logic [47:0] sent      [$];

  csa_out_axis_packer #(
    .IN_WIDTH(48), .AXIS_DATA_WIDTH(32), .FIFO_DEPTH(16), .FRAME_RESULTS(8)
  ) dut (
    .clk(clk), .rst(rst), .in_wen(in_wen), .in_wdata(in_wdata),
    .in_error_full(in_error_full), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .axis_m_r_ready(axis_m_r_ready),
    .frame_count(frame_count), .overflow_count(overflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      beat_data.push_back(m_axis_tdata);
      beat_last.push_back(m_axis_tlast);
      beat_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not end, required end before 2 ms");
    $fatal(1, "[TB] global timeout");
  end

  function automatic logic [47:0] res(input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {16'hC000 | kk, 16'hB000 | kk, 16'hA000 | kk};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_wen = 1'b0;
    in_wdata = '0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    beat_data.delete();
    beat_last.delete();
    beat_cyc.delete();
    sent.delete();
  endtask

  task automatic write_res(input logic [47:0] d);
    in_wen = 1'b1;
    in_wdata = d;
    @(posedge clk);
    #1 in_wen = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int limit);
    int t;
    t = 0;
    while (beat_data.size() < n && t < limit) begin
      @(posedge clk);
      #1 t++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (beat_data.size() != n) begin
      errors++;
      $display("[TB] FAIL beat_count: got %0d beats, required %0d", beat_data.size(), n);
    end
  endtask

  task automatic check_unpack();
    logic [47:0] a;
    logic [47:0] b;
    for (int i = 0; i < sent.size() / 2; i++) begin
      checks++;
      if (3 * i + 2 >= beat_data.size()) begin
        errors++;
        $display("[TB] FAIL unpack_pair%0d: beats missing, required %h %h", i, sent[2*i], sent[2*i+1]);
      end else begin
        a = {beat_data[3*i+1][15:0], beat_data[3*i]};
        b = {beat_data[3*i+2], beat_data[3*i+1][31:16]};
        if ({b, a} !== {sent[2*i+1], sent[2*i]}) begin
          errors++;
          $display("[TB] FAIL unpack_pair%0d: got %h %h, required %h %h", i, a, b, sent[2*i], sent[2*i+1]);
        end
      end
    end
  endtask

  task automatic check_tlast();
    logic exp_last;
    for (int j = 0; j < beat_data.size(); j++) begin
      exp_last = ((j % 12) == 11);
      checks++;
      if (beat_last[j] !== exp_last) begin
        errors++;
        $display("[TB] FAIL tlast_beat%0d: got %b, required %b", j, beat_last[j], exp_last);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_wen = 1'b0;
    in_wdata = '0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, axis_m_r_ready, in_error_full} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b, required 0000", {m_axis_tvalid, m_axis_tlast, axis_m_r_ready, in_error_full});
    end
    checks++;
    if (m_axis_tdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_tdata: got %h, required 00000000", m_axis_tdata);
    end
    checks++;
    if (frame_count !== 32'h0 || overflow_count !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_counters: got %h/%h, required 0/0", frame_count, overflow_count);
    end
    rst = 1'b0;
    m_axis_tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || axis_m_r_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_writes: got tvalid=%b ready=%b, required 0 0", m_axis_tvalid, axis_m_r_ready);
    end
  endtask

  task automatic test_basic_pair();
    do_reset();
    m_axis_tready = 1'b1;
    write_res(48'h0000_1111_2222);
    write_res(48'h3333_4444_5555);
    checks++;
    if (m_axis_tvalid !== 1'b0 || axis_m_r_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_after_2nd_write: got tvalid=%b ready=%b, required 0 1", m_axis_tvalid, axis_m_r_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h1111_2222) begin
      errors++;
      $display("[TB] FAIL basic_first_beat: got tvalid=%b tdata=%h, required 1 11112222", m_axis_tvalid, m_axis_tdata);
    end
    wait_beats(3, 20);
    if (beat_data.size() == 3) begin
      checks++;
      if ({beat_data[0], beat_data[1], beat_data[2]} !== {32'h1111_2222, 32'h5555_0000, 32'h3333_4444}) begin
        errors++;
        $display("[TB] FAIL basic_beats: got %h %h %h, required 11112222 55550000 33334444", beat_data[0], beat_data[1], beat_data[2]);
      end
      checks++;
      if ({beat_last[0], beat_last[1], beat_last[2]} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL basic_tlast: got %b%b%b, required 000", beat_last[0], beat_last[1], beat_last[2]);
      end
    end
    checks++;
    if (m_axis_tvalid !== 1'b0 || axis_m_r_ready !== 1'b0 || frame_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL basic_drained: got tvalid=%b ready=%b frames=%0d, required 0 0 0", m_axis_tvalid, axis_m_r_ready, frame_count);
    end
  endtask

  task automatic test_frame();
    do_reset();
    m_axis_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sent.push_back(res(k));
      write_res(res(k));
    end
    wait_beats(12, 100);
    check_tlast();
    check_unpack();
    checks++;
    if (frame_count !== 32'd1) begin
      errors++;
      $display("[TB] FAIL frame_count_1: got %0d, required 1", frame_count);
    end
    checks++;
    if (beat_cyc.size() < 12 || beat_cyc[11] - beat_cyc[0] != 11) begin
      errors++;
      $display("[TB] FAIL frame1_no_bubble: got %0d beats, span wrong, required 12 beats in 12 cycles", beat_cyc.size());
    end
    for (int k = 8; k < 16; k++) begin
      sent.push_back(res(k));
      write_res(res(k));
    end
    wait_beats(24, 100);
    check_tlast();
    check_unpack();
    checks++;
    if (frame_count !== 32'd2) begin
      errors++;
      $display("[TB] FAIL frame_count_2: got %0d, required 2", frame_count);
    end
    checks++;
    if (beat_cyc.size() < 24 || beat_cyc[23] - beat_cyc[12] != 11) begin
      errors++;
      $display("[TB] FAIL frame2_no_bubble: got %0d beats, span wrong, required 12 beats in 12 cycles", beat_cyc.size());
    end
  endtask

  task automatic test_overflow();
    logic [47:0] r0;
    r0 = res(0);
    do_reset();
    m_axis_tready = 1'b0;
    // The first pair moves into the packer registers, so 18 writes fit.
    for (int k = 0; k < 20; k++) begin
      if (k < 18) sent.push_back(res(k));
      write_res(res(k));
      checks++;
      if (in_error_full !== (k >= 16)) begin
        errors++;
        $display("[TB] FAIL full_after_write%0d: got %b, required %b", k, in_error_full, (k >= 16));
      end
    end
    checks++;
    if (overflow_count !== 16'd2) begin
      errors++;
      $display("[TB] FAIL overflow_count: got %0d, required 2", overflow_count);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== r0[31:0]) begin
      errors++;
      $display("[TB] FAIL stall_hold: got tvalid=%b tdata=%h, required 1 %h", m_axis_tvalid, m_axis_tdata, r0[31:0]);
    end
    m_axis_tready = 1'b1;
    wait_beats(27, 200);
    check_unpack();
    check_tlast();
    checks++;
    if (frame_count !== 32'd2 || axis_m_r_ready !== 1'b0 || in_error_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_drain: got frames=%0d ready=%b full=%b, required 2 0 0", frame_count, axis_m_r_ready, in_error_full);
    end
  endtask

  task automatic test_random_ready();
    int n;
    int guard;
    do_reset();
    n = 0;
    guard = 0;
    while ((n < 64 || beat_data.size() < 96) && guard < 3000) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      if (n < 64 && !in_error_full) begin
        in_wen = 1'b1;
        in_wdata = res(n + 100);
        sent.push_back(res(n + 100));
        n++;
      end else begin
        in_wen = 1'b0;
      end
      @(posedge clk);
      #1 guard++;
    end
    in_wen = 1'b0;
    m_axis_tready = 1'b1;
    wait_beats(96, 50);
    check_unpack();
    checks++;
    if (frame_count !== 32'd8 || overflow_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL random_counters: got frames=%0d drops=%0d, required 8 0", frame_count, overflow_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [47:0] r2;
    logic [47:0] r3;
    r2 = res(2);
    r3 = res(3);
    do_reset();
    m_axis_tready = 1'b1;
    write_res(res(0));
    write_res(res(1));
    wait_beats(3, 20);
    m_axis_tready = 1'b0;
    write_res(r2);
    write_res(r3);
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    @(posedge clk);
    #1 m_axis_tready = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {r3[15:0], r2[47:32]}) begin
      errors++;
      $display("[TB] FAIL mid_b1_beat: got tvalid=%b tdata=%h, required 1 %h", m_axis_tvalid, m_axis_tdata, {r3[15:0], r2[47:32]});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, axis_m_r_ready, in_error_full} !== 4'b0000 || m_axis_tdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_async_reset: got flags=%b tdata=%h, required 0000 00000000", {m_axis_tvalid, m_axis_tlast, axis_m_r_ready, in_error_full}, m_axis_tdata);
    end
    do_reset();
    m_axis_tready = 1'b1;
    for (int k = 10; k < 18; k++) begin
      sent.push_back(res(k));
      write_res(res(k));
    end
    wait_beats(12, 100);
    check_tlast();
    check_unpack();
    checks++;
    if (frame_count !== 32'd1) begin
      errors++;
      $display("[TB] FAIL mid_frame_count: got %0d, required 1", frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_frame();
    test_overflow();
    test_random_ready();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_out_axis_packer.md
Name: csa_out_axis_packer

Overview:
Downstream stage of the CSA calculation/RAM block. It accepts 48-bit CSA results through that block's output write interface (wen/wdata/error_full), buffers them in a small FIFO, and densely packs result pairs into 32-bit AXI-Stream beats (2 results -> 3 beats). It frames the stream with tlast every FRAME_RESULTS results and returns a "data available" flag to the register map.

Parameters:
IN_WIDTH, 48, width of one CSA result; fixed by the packing format, no other value supported
AXIS_DATA_WIDTH, 32, m_axis_tdata width; fixed by the packing format
FIFO_DEPTH, 16, result FIFO entries; power of 2, >= 4
FRAME_RESULTS, 8, results per AXIS packet; even, >= 2

Ports:
clk  in  1  single clock; the CSA calc clock domain
rst  in  1  asynchronous, active-high reset
in_wen  in  1  result write strobe from the CSA output stage
in_wdata  in  IN_WIDTH  result {out2[15:0], out1[15:0], out0[15:0]}
in_error_full  out  1  backpressure to the writer
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
m_axis_tdata  out  AXIS_DATA_WIDTH  AXIS data
m_axis_tlast  out  1  last beat of a frame
axis_m_r_ready  out  1  data pending; status bit for the register map
frame_count  out  32  completed frames (tlast handshakes); wraps at 2^32
overflow_count  out  16  dropped writes; saturates at 16'hFFFF

Behaviour:
- Async reset (rst=1): FIFO empty, count=0, state IDLE, every output 0 (including tdata, tlast, both counters). Reset mid-packet discards the partial pair/frame; no tlast is emitted for it.
- FIFO: register array with wr_ptr, rd_ptr, and count (0..FIFO_DEPTH).
- in_error_full = (count >= FIFO_DEPTH-1). The writer checks full one or more cycles before writing, so one slot of headroom is kept.
- Write when count==FIFO_DEPTH: data dropped, FIFO unchanged, overflow_count++ (saturating).
- Write and pair-pop on the same edge: count <= count + 1 - 2. The write is accepted because count is checked before the pop.
- Packer FSM states: IDLE, B0, B1, B2.
  - IDLE: if count >= 2 on an edge, pop two entries (A = older, B = newer) into regs and go to B0 with tvalid=1. A write on the same edge is not included in the pair.
  - B0: tdata = A[31:0].
  - B1: tdata = {B[15:0], A[47:32]}.
  - B2: tdata = B[47:16].
  - Each state holds until tvalid & tready, then advances B0->B1->B2->IDLE.
  - tdata, tlast, and tvalid are registered and stable while tvalid=1 and tready=0.
  - From B2 on handshake: if count >= 2, load the next pair and go directly to B0 (no bubble, tvalid stays 1); else go to IDLE with tvalid=0.
- Latency: with the FIFO holding 1 entry, a write sampled at edge T gives count=2 after T, the pair loads at T+1, and tvalid=1 after T+1. Sustained throughput is 3 beats per 2 results.
- Framing:
  - res_idx counts 0..FRAME_RESULTS-2 in steps of 2.
  - tlast=1 only on the B2 beat when res_idx == FRAME_RESULTS-2.
  - On the B2 handshake: res_idx <= 0 if it was the last pair, else res_idx + 2.
  - frame_count increments on each tvalid & tready & tlast.
- An odd leftover result stays in the FIFO until its partner arrives. There is no flush.
- axis_m_r_ready = m_axis_tvalid | (count >= 2), registered.
- m_axis_tready toggling mid-beat never duplicates or skips a beat.

Test Plan:
- Reset then idle -> all outputs 0; in_error_full=0; tvalid stays 0 with no writes.
- Write 48'h0000_1111_2222 then 48'h3333_4444_5555, tready=1 -> beats 32'h1111_2222, 32'h5555_0000, 32'h3333_4444; tvalid first high on the edge after the second write; tlast=0.
- FRAME_RESULTS=8, 8 writes, tready=1 -> 12 beats, tlast only on beat 12, frame_count=1; 16 writes -> frame_count=2 and no bubble between pairs.
- tready held 0 with 20 writes attempted, FIFO_DEPTH=16 -> in_error_full=1 at count 15; the writes arriving at count 16 are dropped and overflow_count equals the number dropped; tdata held stable; releasing tready drains the packets in order.
- Random tready (50%) with 64 sequential results -> unpacked stream equals the input sequence exactly.
- Assert rst during beat B1 -> outputs 0 immediately (async); after release a new pair produces a correctly packed frame with res_idx restarted at 0.
